// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result streaming path: default sizes,
// streamer state encoding and an address bit-reversal helper.
package fft_pkg;

  localparam int FFT_N_DEF  = 512;
  localparam int FFT_BW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } strm_state_e;

  // Reverse the low m bits of x; bits at and above m come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] x, input int m);
    logic [31:0] r;
    int          j;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      j = m - 1 - i;
      if (j >= 0) r[i] = x[j[4:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bin_streamer_mag2_pipe.sv
// Square-and-add pipeline: takes {re, im} the cycle after the RAM read,
// registers both squares, then registers their sum. A valid/index
// sideband rides alongside so every result leaves with its bin number.
module mag2_pipe #(
  parameter int BW = 16,
  parameter int IW = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vld_i,      // read issued this cycle
  input  logic [IW-1:0]   idx_i,      // bin index of the issued read
  input  logic [2*BW-1:0] rd_data_i,  // {re, im}, one cycle after vld_i
  output logic            load_o,
  output logic [IW-1:0]   bin_index_o,
  output logic [2*BW-1:0] mag2_o,
  output logic            inflight_o  // a bin is still ahead of the output stage
);

  // vld_pipe[0]: read issued, [1]: rd_data present, [2]: squares held, [3]: sum out
  logic [3:0] vld_pipe;
  logic [IW-1:0] idx1_q, idx2_q, idx3_q;
  logic signed [BW-1:0]   re, im;
  logic signed [2*BW-1:0] sq_re_q, sq_im_q;
  logic [2*BW-1:0]        sum_d, mag2_q;

  assign vld_pipe[0] = vld_i;
  assign re          = rd_data_i[2*BW-1:BW];
  assign im          = rd_data_i[BW-1:0];
  // Each square is at most 2^(2BW-2), so the unsigned sum cannot overflow 2BW bits.
  assign sum_d       = $unsigned(sq_re_q) + $unsigned(sq_im_q);

  // Valid shift register; cleared on reset so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_pipe[3:1] <= '0;
    else       vld_pipe[3:1] <= vld_pipe[2:0];
  end

  // Data and index stages; only advance on valid so outputs hold between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx1_q  <= '0;
      idx2_q  <= '0;
      idx3_q  <= '0;
      sq_re_q <= '0;
      sq_im_q <= '0;
      mag2_q  <= '0;
    end else begin
      if (vld_pipe[0]) idx1_q <= idx_i;
      if (vld_pipe[1]) begin
        idx2_q  <= idx1_q;
        sq_re_q <= (2*BW)'(re) * (2*BW)'(re);
        sq_im_q <= (2*BW)'(im) * (2*BW)'(im);
      end
      if (vld_pipe[2]) begin
        idx3_q <= idx2_q;
        mag2_q <= sum_d;
      end
    end
  end

  assign load_o      = vld_pipe[3];
  assign bin_index_o = idx3_q;
  assign mag2_o      = mag2_q;
  assign inflight_o  = |vld_pipe[2:1];

endmodule

// File: rtl/fft_bin_streamer.sv
// Reads NUM_BINS complex bins from the FFT result RAM after start, streams
// |X[k]|^2 with its natural bin index, then pulses done once the pipe is empty.
module fft_bin_streamer
  import fft_pkg::*;
#(
  parameter int N         = FFT_N_DEF,
  parameter int bit_width = FFT_BW_DEF,
  parameter int M         = $clog2(N),
  parameter int NUM_BINS  = N / 2,
  parameter int BIT_REV   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [M-1:0]           rd_addr,
  output logic                   rd_en,
  input  logic [2*bit_width-1:0] rd_data,
  output logic                   load,
  output logic [M-1:0]           bin_index,
  output logic [2*bit_width-1:0] mag2,
  output logic                   done,
  output logic                   busy
);

  localparam logic [M-1:0] LAST = M'(NUM_BINS - 1);

  strm_state_e  state_q;
  logic [M-1:0] cnt_q, cnt_d;
  logic [M-1:0] rd_addr_q;
  logic         rd_en_q, done_q, busy_q;
  logic         inflight;

  // RAM address for bin k: natural order or M-bit reversed.
  function automatic logic [M-1:0] addr_of(input logic [M-1:0] k);
    logic [31:0] t;
    if (BIT_REV != 0) t = bit_reverse(32'(k), M);
    else              t = 32'(k);
    return t[M-1:0];
  endfunction

  assign cnt_d = cnt_q + 1'b1;

  // Frame sequencer; every output it drives is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= READ;
            cnt_q     <= '0;
            rd_addr_q <= addr_of('0);
            rd_en_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        READ: begin
          if (cnt_q == LAST) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_d;
            rd_addr_q <= addr_of(cnt_d);
          end
        end
        DRAIN: begin
          // Only the output stage may still hold a bin, so done lands one
          // cycle after the final load with load already low.
          if (!inflight) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          // A start arriving alongside done is dropped by design.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mag2_pipe #(
    .BW (bit_width),
    .IW (M)
  ) u_mag2 (
    .clk         (clk),
    .reset       (reset),
    .vld_i       (rd_en_q),
    .idx_i       (cnt_q),
    .rd_data_i   (rd_data),
    .load_o      (load),
    .bin_index_o (bin_index),
    .mag2_o      (mag2),
    .inflight_o  (inflight)
  );

  assign rd_addr = rd_addr_q;
  assign rd_en   = rd_en_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Scoreboard bench for fft_bin_streamer: three instances (natural order,
// bit-reversed, full-size with a peak tracker), RAM models and expected queues.
module tb_fft_bin_streamer;

  typedef struct {
    int          idx;
    logic [31:0] mag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mag_of(input logic [31:0] d);
    longint r, i;
    r = longint'($signed(d[31:16]));
    i = longint'($signed(d[15:0]));
    return 32'(r * r + i * i);
  endfunction

  function automatic int br3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  function automatic logic [31:0] ramA(input int mode, input int a);
    logic signed [15:0] re, im;
    if (mode == 0) begin
      re = 16'(a); im = 16'sd0;
    end else begin
      case (a)
        0:       begin re = 16'sh8000; im = 16'sh8000; end
        1:       begin re = 16'sd3;    im = -16'sd4;   end
        default: begin re = 16'(a);    im = 16'(a);    end
      endcase
    end
    return {re, im};
  endfunction

  function automatic logic [31:0] ramB(input int a);
    return {16'(a), 16'sd1};
  endfunction

  function automatic logic [31:0] ramC(input int a);
    return (a == 37) ? {16'sd30, 16'sd10} : {16'sd3, 16'sd1};
  endfunction

  // ---------------- instance A: N=8, 4 bins, natural order
  logic        a_start = 1'b0;
  logic [2:0]  a_rd_addr, a_bin_index;
  logic        a_rd_en, a_load, a_done, a_busy;
  logic [31:0] a_rd_data = '0, a_mag2;
  int          modeA = 0;

  fft_bin_streamer #(.N(8), .bit_width(16), .NUM_BINS(4), .BIT_REV(0)) dut_a (
    .clk(clk), .reset(rst), .start(a_start), .rd_addr(a_rd_addr), .rd_en(a_rd_en),
    .rd_data(a_rd_data), .load(a_load), .bin_index(a_bin_index), .mag2(a_mag2),
    .done(a_done), .busy(a_busy));

  always @(posedge clk) if (a_rd_en) a_rd_data <= ramA(modeA, int'(a_rd_addr));

  // ---------------- instance B: N=8, 8 bins, bit-reversed addressing
  logic        b_start = 1'b0;
  logic [2:0]  b_rd_addr, b_bin_index;
  logic        b_rd_en, b_load, b_done, b_busy;
  logic [31:0] b_rd_data = '0, b_mag2;

  fft_bin_streamer #(.N(8), .bit_width(16), .NUM_BINS(8), .BIT_REV(1)) dut_b (
    .clk(clk), .reset(rst), .start(b_start), .rd_addr(b_rd_addr), .rd_en(b_rd_en),
    .rd_data(b_rd_data), .load(b_load), .bin_index(b_bin_index), .mag2(b_mag2),
    .done(b_done), .busy(b_busy));

  always @(posedge clk) if (b_rd_en) b_rd_data <= ramB(int'(b_rd_addr));

  // ---------------- instance C: default N=512, 256 bins, feeds a peak tracker
  logic        c_start = 1'b0;
  logic [8:0]  c_rd_addr, c_bin_index;
  logic        c_rd_en, c_load, c_done, c_busy;
  logic [31:0] c_rd_data = '0, c_mag2;

  fft_bin_streamer dut_c (
    .clk(clk), .reset(rst), .start(c_start), .rd_addr(c_rd_addr), .rd_en(c_rd_en),
    .rd_data(c_rd_data), .load(c_load), .bin_index(c_bin_index), .mag2(c_mag2),
    .done(c_done), .busy(c_busy));

  always @(posedge clk) if (c_rd_en) c_rd_data <= ramC(int'(c_rd_addr));

  // ---------------- scoreboards and monitors
  exp_t qA[$], qB[$];
  int   qBa[$];
  exp_t ea, eb;
  int   a_loads = 0, a_dones = 0, a_first = -1, a_last = -1, a_done_cyc = -1, a_st = 0;
  int   b_loads = 0, b_dones = 0;
  int   c_loads = 0, c_dones = 0;
  int   pk_run_bin = 0, pk_bin = -1;
  logic [31:0] pk_run_mag = '0, pk_mag = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_load) begin
        if (qA.size() == 0) chk("A_unexpected_load", a_load, 0);
        else begin
          ea = qA.pop_front();
          chk("A_idx", a_bin_index, ea.idx);
          chk("A_mag", a_mag2, ea.mag);
        end
        a_loads++;
        if (a_first < 0) a_first = cyc;
        a_last = cyc;
      end
      if (a_done) begin
        a_dones++;
        a_done_cyc = cyc;
        chk("A_load_in_done", a_load, 0);
        chk("A_busy_in_done", a_busy, 1);
      end
      if (b_rd_en) begin
        if (qBa.size() == 0) chk("B_unexpected_rd", b_rd_en, 0);
        else chk("B_rd_addr", b_rd_addr, qBa.pop_front());
      end
      if (b_load) begin
        if (qB.size() == 0) chk("B_unexpected_load", b_load, 0);
        else begin
          eb = qB.pop_front();
          chk("B_idx", b_bin_index, eb.idx);
          chk("B_mag", b_mag2, eb.mag);
        end
        b_loads++;
      end
      if (b_done) b_dones++;
      if (c_load) begin
        c_loads++;
        if (c_mag2 > pk_run_mag) begin
          pk_run_mag = c_mag2;
          pk_run_bin = int'(c_bin_index);
        end
      end
      if (c_done) begin
        c_dones++;
        pk_bin = pk_run_bin;
        pk_mag = pk_run_mag;
      end
    end
  end

  // Queue the expected stream for A and pulse its start.
  task automatic frame_a(input int mode);
    exp_t e;
    modeA = mode;
    for (int k = 0; k < 4; k++) begin
      e.idx = k;
      e.mag = mag_of(ramA(mode, k));
      qA.push_back(e);
    end
    a_first = -1;
    @(posedge clk); #1 a_start = 1'b1; a_st = cyc;
    @(posedge clk); #1 a_start = 1'b0;
    chk("A_busy_after_start", a_busy, 1);
  endtask

  task automatic wait_done_a(input int prev, input int bound);
    int n = 0;
    while (a_dones == prev && n < bound) begin
      @(posedge clk); n++;
    end
    #1;
    if (a_dones == prev) chk("A_done_timeout", a_dones, prev + 1);
  endtask

  initial begin
    int prev, n;
    exp_t e;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_load", a_load, 0);
    chk("rst_done", a_done, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_rd_en", a_rd_en, 0);
    chk("rst_mag2", a_mag2, 0);
    chk("rst_bin_index", a_bin_index, 0);
    chk("rst_rd_addr", b_rd_addr, 0);
    rst = 1'b0;

    // ramp re=k, im=0: latency and done placement
    prev = a_dones;
    frame_a(0);
    wait_done_a(prev, 40);
    chk("T1_first_load_cycle", a_first, a_st + 4);
    chk("T1_done_after_last", a_done_cyc, a_last + 1);
    chk("T1_queue_empty", qA.size(), 0);
    repeat (2) @(posedge clk); #1;
    chk("T1_busy_low", a_busy, 0);

    // extreme values
    prev = a_dones;
    frame_a(1);
    wait_done_a(prev, 40);
    chk("T3_queue_empty", qA.size(), 0);
    chk("T3_mag_hold", a_mag2, mag_of(ramA(1, 3)));

    // start during READ and start in the done cycle are both ignored
    repeat (3) @(posedge clk);
    prev = a_dones;
    frame_a(0);
    repeat (2) @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (4) @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    chk("T4_busy_after_done", a_busy, 0);
    repeat (12) @(posedge clk); #1;
    chk("T4_single_done", a_dones, prev + 1);
    chk("T4_done_cycle", a_done_cyc, a_st + 8);
    chk("T4_queue_empty", qA.size(), 0);
    chk("T4_idle_busy", a_busy, 0);

    // reset mid-frame
    prev = a_loads;
    frame_a(0);
    n = 0;
    while (a_loads < prev + 2 && n < 20) begin
      @(posedge clk); n++;
    end
    if (a_loads < prev + 2) chk("T5_load_timeout", a_loads, prev + 2);
    #2 rst = 1'b1;
    #1;
    chk("T5_async_load", a_load, 0);
    chk("T5_async_done", a_done, 0);
    chk("T5_async_busy", a_busy, 0);
    qA.delete();
    prev = a_dones;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("T5_no_done", a_dones, prev);
    frame_a(0);
    wait_done_a(prev, 40);
    chk("T5_restart_first", a_first, a_st + 4);
    chk("T5_queue_empty", qA.size(), 0);

    // bit-reversed addressing
    for (int k = 0; k < 8; k++) begin
      e.idx = k;
      e.mag = mag_of(ramB(br3(k)));
      qB.push_back(e);
      qBa.push_back(br3(k));
    end
    prev = b_dones;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    n = 0;
    while (b_dones == prev && n < 40) begin
      @(posedge clk); n++;
    end
    #1;
    chk("T2_done", b_dones, prev + 1);
    chk("T2_loads", b_loads, 8);
    chk("T2_addr_queue_empty", qBa.size(), 0);
    chk("T2_queue_empty", qB.size(), 0);

    // full-size frame into a peak tracker
    pk_run_mag = '0;
    pk_run_bin = 0;
    prev = c_dones;
    @(posedge clk); #1 c_start = 1'b1;
    @(posedge clk); #1 c_start = 1'b0;
    n = 0;
    while (c_dones == prev && n < 400) begin
      @(posedge clk); n++;
    end
    #1;
    chk("T6_done", c_dones, prev + 1);
    chk("T6_loads", c_loads, 256);
    chk("T6_peak_bin", pk_bin, 37);
    chk("T6_peak_mag", pk_mag, 1000);
    chk("T6_last_index", c_bin_index, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
